// File: rtl/mem_array_ctrl.sv
// Single-port word-addressed memory with 1..4 beat read/write bursts, per-byte
// write enables and a configurable-depth read data pipeline.
module mem_array_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     Addr,
    input  logic [DATA_W-1:0]     DataIn,
    input  logic [DATA_W/8-1:0]   ByteEn,
    input  logic                  rdEn,
    input  logic                  wrEn,
    input  logic [1:0]            BurstLen,
    output logic                  Ready,
    output logic [DATA_W-1:0]     DataOut,
    output logic                  DataValid,
    output logic                  Error
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_BURST = 2'd1,
        ST_WR_BURST = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   addr_s;
    logic [1:0]          remain_r;
    logic [1:0]          remain_s;
    logic                issue_rd_s;
    logic                issue_wr_s;
    logic                illegal_s;
    logic [ADDR_W-1:0]   issue_addr_s;
    logic                error_r;

    logic [DATA_W-1:0]   mem_r [2**ADDR_W];
    logic [RD_LAT-1:0]   vld_r;
    logic [DATA_W-1:0]   dat_r [RD_LAT];

    // Ready is forced low for as long as reset is asserted.
    assign Ready     = (state_r == ST_IDLE) && !reset;
    assign DataOut   = dat_r[RD_LAT-1];
    assign DataValid = vld_r[RD_LAT-1];
    assign Error     = error_r;

    // Next-state logic; beat 0 issues from the live inputs, later beats from the latched address.
    always_comb begin
        state_s      = state_r;
        addr_s       = addr_r;
        remain_s     = remain_r;
        issue_rd_s   = 1'b0;
        issue_wr_s   = 1'b0;
        illegal_s    = 1'b0;
        issue_addr_s = addr_r;
        case (state_r)
            ST_IDLE: begin
                if (!reset && (rdEn ^ wrEn)) begin
                    issue_rd_s   = rdEn;
                    issue_wr_s   = wrEn;
                    issue_addr_s = Addr;
                    addr_s       = Addr + ADDR_W'(1);
                    remain_s     = BurstLen;
                    if (BurstLen != 2'd0) begin
                        state_s = rdEn ? ST_RD_BURST : ST_WR_BURST;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (!reset && rdEn && wrEn) begin
                    illegal_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_BURST, ST_WR_BURST: begin
                if (!reset) begin
                    issue_rd_s = (state_r == ST_RD_BURST);
                    issue_wr_s = (state_r == ST_WR_BURST);
                    addr_s     = addr_r + ADDR_W'(1);
                    remain_s   = remain_r - 2'd1;
                    if (remain_r == 2'd1) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM, burst address and beat counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            addr_r   <= '0;
            remain_r <= 2'd0;
        end else begin
            state_r  <= state_s;
            addr_r   <= addr_s;
            remain_r <= remain_s;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (issue_wr_s) begin
            for (int b = 0; b < BE_W; b++) begin
                if (ByteEn[b]) begin
                    mem_r[issue_addr_s][b*8 +: 8] <= DataIn[b*8 +: 8];
                end
            end
        end
    end

    // Read pipeline; each stage keeps its data until a new valid beat arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_r[i] <= '0;
            end
        end else begin
            vld_r[0] <= issue_rd_s;
            if (issue_rd_s) begin
                dat_r[0] <= mem_r[issue_addr_s];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
                if (vld_r[i-1]) begin
                    dat_r[i] <= dat_r[i-1];
                end
            end
        end
    end

    // Error pulse for a simultaneous read and write request.
    always_ff @(posedge clk) begin
        if (reset) begin
            error_r <= 1'b0;
        end else begin
            error_r <= illegal_s;
        end
    end

endmodule

// File: doc/mem_array_ctrl.md
MEM_ARRAY_CTRL -- requirements
Module: mem_array_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 12, address width in words.
REQ-002 SHALL provide parameter DATA_W, default 16, word width; a multiple of 8.
REQ-003 SHALL provide parameter RD_LAT, default 1, read latency in cycles; legal range 1..4.
REQ-004 SHALL provide port clk, input, 1, single clock; all state changes on the rising edge.
REQ-005 SHALL provide port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL provide port Addr, input, ADDR_W, start word address of a command.
REQ-007 SHALL provide port DataIn, input, DATA_W, write data for the current beat.
REQ-008 SHALL provide port ByteEn, input, DATA_W/8, per-byte write enable for the current beat.
REQ-009 SHALL provide port rdEn, input, 1, read command request.
REQ-010 SHALL provide port wrEn, input, 1, write command request.
REQ-011 SHALL provide port BurstLen, input, 2, beat count minus 1 (1..4 beats).
REQ-012 SHALL provide port Ready, output, 1, high when a new command can be accepted.
REQ-013 SHALL provide port DataOut, output, DATA_W, read data.
REQ-014 SHALL provide port DataValid, output, 1, DataOut holds a valid read beat.
REQ-015 SHALL provide port Error, output, 1, one-cycle pulse on an illegal command.

Function
REQ-016 SHALL hold a 2**ADDR_W x DATA_W storage array; contents are not cleared by reset.
REQ-017 SHALL accept a command in any cycle where Ready=1 and exactly one of rdEn/wrEn is 1 (the acceptance cycle, A); Addr, BurstLen and op are latched at A.
REQ-018 SHALL implement FSM states IDLE, RD_BURST, WR_BURST; IDLE->RD_BURST/WR_BURST on acceptance when N=BurstLen+1>1; burst state->IDLE after the last beat issues.
REQ-019 SHALL issue beat k (k=0..N-1) in cycle A+k at address (Addr+k) mod 2**ADDR_W; the address wraps from all-ones to 0.
REQ-020 SHALL drive Ready=0 in cycles A+1..A+N-1 and Ready=1 in cycle A+N; a 1-beat command leaves Ready=1, so back-to-back commands are allowed.
REQ-021 SHALL write beat k using DataIn/ByteEn sampled in cycle A+k, updating only the bytes whose ByteEn bit is 1.
REQ-022 SHALL present read beat k on DataOut with DataValid=1 in cycle A+k+RD_LAT, through an RD_LAT-deep pipeline; DataValid SHALL be 0 in every other cycle.
REQ-023 SHALL hold the last valid value on DataOut while DataValid=0.
REQ-024 SHALL ensure a read issued the cycle after a write to the same address returns the new data; write-then-read ordering is strict.
REQ-025 SHALL allow a new read to be accepted while earlier read beats are still in the pipeline; beats SHALL emerge in issue order with no gaps or overlap.
REQ-026 SHALL treat rdEn=1 and wrEn=1 together with Ready=1 as illegal: no access, FSM stays IDLE, Error=1 in the following cycle only.
REQ-027 SHALL ignore rdEn, wrEn, Addr and BurstLen while Ready=0, and SHALL NOT raise Error for them.

Reset
REQ-028 SHALL drive, in the cycle after reset is sampled high: FSM=IDLE, Ready=1, DataValid=0, DataOut=0, Error=0, read pipeline flushed, beat counter=0.
REQ-029 SHALL hold Ready=0 while reset is high.
REQ-030 SHALL, on reset mid-burst, abandon the burst immediately: no further writes, and no DataValid for any beat already in flight; beats already written stay written.

Verification
REQ-031 SHALL cover: single write Addr=0x005, DataIn=0xBEEF, ByteEn=11, then 1-beat read of 0x005 with RD_LAT=1 -> DataOut=0xBEEF, DataValid=1 exactly 1 cycle after read acceptance.
REQ-032 SHALL cover: 4-beat write at Addr=0xFFE, data 0x1111..0x4444 -> words 0xFFE,0xFFF,0x000,0x001 hold those values; Ready=0 for 3 cycles, then 1.
REQ-033 SHALL cover: write 0xAAAA to 0x010, then write 0x55FF with ByteEn=01 -> read returns 0xAAFF.
REQ-034 SHALL cover: rdEn=wrEn=1 with Ready=1 -> Error=1 for one cycle, memory unchanged, Ready stays 1.
REQ-035 SHALL cover: RD_LAT=3, two back-to-back 2-beat reads -> DataValid high for 4 consecutive cycles starting at A+3, data in address order.
REQ-036 SHALL cover: reset asserted in cycle A+1 of a 4-beat read -> no DataValid afterwards, Ready=1 and DataOut=0 in the cycle after reset.
